// File: rtl/audio_pkg.sv
// Shared audio types: note encodings, note lengths, sequencer states and the
// constant melody sheets read by melody_rom.
package audio_pkg;

    typedef enum logic [3:0] {
        do_     = 4'h0,
        doD     = 4'h1,
        re      = 4'h2,
        reD     = 4'h3,
        mi      = 4'h4,
        fa      = 4'h5,
        faD     = 4'h6,
        sol     = 4'h7,
        solD    = 4'h8,
        la      = 4'h9,
        laD     = 4'hA,
        si      = 4'hB,
        do_H    = 4'hC,
        doD_H   = 4'hD,
        re_H    = 4'hE,
        silence = 4'hF
    } musicNote;

    // Note length in beats; 0 terminates a melody.
    typedef logic [3:0] note_len_t;

    typedef struct packed {
        musicNote  tone;
        note_len_t len;
    } note_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP
    } seq_state_t;

    // Entries stored per melody; reads past this depth return length 0.
    localparam int unsigned MELODY_DEPTH = 8;
    // Number of melody sheets physically present in the table.
    localparam int unsigned MELODY_COUNT = 8;

    localparam note_t MELODY_0 [MELODY_DEPTH] = '{
        '{sol, 4'd2}, '{mi, 4'd2}, '{silence, 4'd1}, '{mi, 4'd2},
        '{fa, 4'd2}, '{re, 4'd2}, '{silence, 4'd0}, '{silence, 4'd0}};
    localparam note_t MELODY_1 [MELODY_DEPTH] = '{
        '{do_, 4'd1}, '{mi, 4'd1}, '{sol, 4'd1}, '{do_H, 4'd4},
        '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}};
    localparam note_t MELODY_2 [MELODY_DEPTH] = '{
        '{re, 4'd2}, '{fa, 4'd2}, '{la, 4'd2}, '{silence, 4'd0},
        '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}};
    localparam note_t MELODY_3 [MELODY_DEPTH] = '{
        '{do_H, 4'd1}, '{si, 4'd1}, '{la, 4'd1}, '{sol, 4'd2},
        '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}};
    localparam note_t MELODY_4 [MELODY_DEPTH] = '{
        '{mi, 4'd1}, '{mi, 4'd1}, '{mi, 4'd2}, '{mi, 4'd1},
        '{mi, 4'd1}, '{mi, 4'd2}, '{silence, 4'd0}, '{silence, 4'd0}};
    localparam note_t MELODY_5 [MELODY_DEPTH] = '{
        '{la, 4'd8}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0},
        '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}};
    localparam note_t MELODY_6 [MELODY_DEPTH] = '{
        '{do_, 4'd1}, '{re, 4'd1}, '{mi, 4'd1}, '{fa, 4'd1},
        '{sol, 4'd1}, '{la, 4'd1}, '{si, 4'd1}, '{do_H, 4'd1}};
    localparam note_t MELODY_7 [MELODY_DEPTH] = '{
        '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0},
        '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}, '{silence, 4'd0}};

    function automatic note_t melody_entry(input logic [2:0] mel, input logic [2:0] idx);
        case (mel)
            3'd0:    melody_entry = MELODY_0[idx];
            3'd1:    melody_entry = MELODY_1[idx];
            3'd2:    melody_entry = MELODY_2[idx];
            3'd3:    melody_entry = MELODY_3[idx];
            3'd4:    melody_entry = MELODY_4[idx];
            3'd5:    melody_entry = MELODY_5[idx];
            3'd6:    melody_entry = MELODY_6[idx];
            default: melody_entry = MELODY_7[idx];
        endcase
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational sheet-music lookup: (melody, note index) -> (tone, length).
// Unknown melodies and indices beyond the stored sheet read as length 0.
module melody_rom
    import audio_pkg::*;
#(
    parameter int NUM_MELODIES = 8,
    parameter int MAX_NOTES    = 32
) (
    input  logic [$clog2(NUM_MELODIES)-1:0] melody,
    input  logic [$clog2(MAX_NOTES)-1:0]    note_index,
    output musicNote                        tone,
    output note_len_t                       len
);

    logic [31:0] mel_ext;
    logic [31:0] idx_ext;
    note_t       entry;

    // Table read with range guards on both melody id and note position.
    always_comb begin
        mel_ext = 32'(melody);
        idx_ext = 32'(note_index);
        entry   = melody_entry(mel_ext[2:0], idx_ext[2:0]);
        tone    = silence;
        len     = '0;
        if (mel_ext < 32'(NUM_MELODIES) && mel_ext < MELODY_COUNT &&
            idx_ext < 32'(MAX_NOTES) && idx_ext < MELODY_DEPTH) begin
            tone = entry.tone;
            len  = entry.len;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody player FSM: prioritised start/pre-emption, per-note beat timing with a
// silent articulation gap, looping, and registered outputs for the tone decoder.
module melody_sequencer
    import audio_pkg::*;
#(
    parameter int NUM_MELODIES  = 8,
    parameter int MAX_NOTES     = 32,
    parameter int CLKS_PER_BEAT = 6_250_000,
    parameter int GAP_CLKS      = 250_000
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            start,
    input  logic [$clog2(NUM_MELODIES)-1:0] melodySel,
    input  logic [1:0]                      prio,
    input  logic                            loop,
    input  logic                            stop,
    output logic [3:0]                      tone,
    output logic                            silenceOutN,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_NOTES)-1:0]    noteIndex
);

    localparam int MW = $clog2(NUM_MELODIES);
    localparam int IW = $clog2(MAX_NOTES);
    localparam int CW = $clog2(15 * CLKS_PER_BEAT + 1);

    localparam logic [CW-1:0] CPB_C    = CW'(CLKS_PER_BEAT);
    localparam logic [CW-1:0] GAP_C    = CW'(GAP_CLKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CLKS - 2);
    localparam logic [IW:0]   IDX_ONE  = (IW + 1)'(1);
    localparam logic [IW:0]   IDX_WRAP = (IW + 1)'(MAX_NOTES);

    seq_state_t    state_q, state_n;
    musicNote      tone_q, tone_n;
    logic          sil_q, busy_q, busy_n, done_q, done_n;
    logic [IW:0]   idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [MW-1:0] mel_q, mel_n;
    logic [1:0]    prio_q, prio_n;
    logic          loop_q, loop_n;

    musicNote      rom_tone;
    note_len_t     rom_len;
    logic          note_end;
    logic [CW-1:0] play_load;

    melody_rom #(
        .NUM_MELODIES (NUM_MELODIES),
        .MAX_NOTES    (MAX_NOTES)
    ) u_rom (
        .melody     (mel_q),
        .note_index (idx_q[IW-1:0]),
        .tone       (rom_tone),
        .len        (rom_len)
    );

    // End of sheet: a length-0 note or the index has run past the last slot.
    always_comb begin
        note_end  = (rom_len == '0) || (idx_q == IDX_WRAP);
        play_load = CW'(rom_len) * CPB_C - GAP_C - CNT_ONE;
    end

    // Next-state and next-output logic; stop beats start, start beats progress.
    always_comb begin
        state_n = state_q;
        tone_n  = tone_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        mel_n   = mel_q;
        prio_n  = prio_q;
        loop_n  = loop_q;
        if (stop) begin
            state_n = IDLE;
            tone_n  = silence;
            busy_n  = 1'b0;
            idx_n   = '0;
            cnt_n   = '0;
            prio_n  = '0;
            loop_n  = 1'b0;
        end else if (start && (state_q == IDLE || prio >= prio_q)) begin
            state_n = FETCH;
            tone_n  = silence;
            busy_n  = 1'b1;
            idx_n   = '0;
            cnt_n   = '0;
            mel_n   = melodySel;
            prio_n  = prio;
            loop_n  = loop;
        end else begin
            case (state_q)
                IDLE: ;
                FETCH: begin
                    if (note_end) begin
                        // Looping only if at least one note has been played.
                        if (loop_q && idx_q != '0) begin
                            idx_n = '0;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            idx_n   = '0;
                            prio_n  = '0;
                            loop_n  = 1'b0;
                        end
                    end else begin
                        state_n = PLAY;
                        tone_n  = rom_tone;
                        cnt_n   = play_load;
                    end
                end
                PLAY: begin
                    if (cnt_q == '0) begin
                        tone_n = silence;
                        // A one-cycle gap is exactly the silent FETCH cycle.
                        if (GAP_CLKS == 1) begin
                            state_n = FETCH;
                            idx_n   = idx_q + IDX_ONE;
                        end else begin
                            state_n = GAP;
                            cnt_n   = GAP_LOAD;
                        end
                    end else begin
                        cnt_n = cnt_q - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_n = FETCH;
                        idx_n   = idx_q + IDX_ONE;
                    end else begin
                        cnt_n = cnt_q - CNT_ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            tone_q  <= silence;
            sil_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            mel_q   <= '0;
            prio_q  <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            tone_q  <= tone_n;
            sil_q   <= (tone_n != silence);
            busy_q  <= busy_n;
            done_q  <= done_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            mel_q   <= mel_n;
            prio_q  <= prio_n;
            loop_q  <= loop_n;
        end
    end

    assign tone        = tone_q;
    assign silenceOutN = sil_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign noteIndex   = idx_q[IW-1:0];

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with short beats (10 clocks, 2-clock gap).
module tb_melody_sequencer;

    localparam int NUM_MEL = 6;
    localparam int MAX_N   = 32;
    localparam int CPB     = 10;
    localparam int GAPC    = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] melodySel = '0;
    logic [1:0] prio = '0;
    logic [3:0] tone;
    logic       silenceOutN;
    logic       busy;
    logic       done;
    logic [4:0] noteIndex;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start;
        logic [2:0] sel;
        logic [1:0] prio;
        logic       loop;
        logic       stop;
        logic [3:0] tone;
        logic       sil;
        logic       busy;
        logic       done;
        int         n;
    } vec_t;

    melody_sequencer #(
        .NUM_MELODIES  (NUM_MEL),
        .MAX_NOTES     (MAX_N),
        .CLKS_PER_BEAT (CPB),
        .GAP_CLKS      (GAPC)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .melodySel   (melodySel),
        .prio        (prio),
        .loop        (loop),
        .stop        (stop),
        .tone        (tone),
        .silenceOutN (silenceOutN),
        .busy        (busy),
        .done        (done),
        .noteIndex   (noteIndex)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compares {tone, silenceOutN, busy, done} as one hex word.
    task automatic check_outs(input string name, input logic [3:0] t, input logic s,
                              input logic b, input logic d);
        check(name, 32'({tone, silenceOutN, busy, done}), 32'({t, s, b, d}));
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   wraps;
        int   dones;
        int   cyc;
        int   last_wrap;
        logic [4:0] prev;

        // Reset state
        @(negedge clk);
        check_outs("reset_outs", 4'hF, 1'b0, 1'b0, 1'b0);
        check("reset_idx", 32'(noteIndex), 32'd0);
        resetN = 1'b1;
        step;
        check_outs("post_reset_idle", 4'hF, 1'b0, 1'b0, 1'b0);

        // Melody 1, no loop, priority 0
        vecs.push_back('{1'b1, 3'd1, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 8});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 8});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 38});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 3});
        // start and stop together while idle
        vecs.push_back('{1'b1, 3'd1, 2'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 2});
        // Out-of-range melody with loop: single FETCH then done
        vecs.push_back('{1'b1, 3'd6, 2'd0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 2});
        // Pre-emption: prio 2 playing, prio 1 ignored, prio 2 takes over
        vecs.push_back('{1'b1, 3'd1, 2'd2, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd2, 2'd1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{1'b1, 3'd2, 2'd2, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 18});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 2});

        foreach (vecs[i]) begin
            start     = vecs[i].start;
            melodySel = vecs[i].sel;
            prio      = vecs[i].prio;
            loop      = vecs[i].loop;
            stop      = vecs[i].stop;
            for (int k = 0; k < vecs[i].n; k++) begin
                step;
                start = 1'b0;
                stop  = 1'b0;
                check_outs($sformatf("vec%0d_cyc%0d", i, k), vecs[i].tone, vecs[i].sil,
                           vecs[i].busy, vecs[i].done);
            end
        end

        // Looping melody 1: three wraps, 71 cycles per pass, never done
        melodySel = 3'd1;
        prio      = 2'd0;
        loop      = 1'b1;
        start     = 1'b1;
        step;
        start     = 1'b0;
        loop      = 1'b0;
        wraps     = 0;
        dones     = 0;
        cyc       = 0;
        last_wrap = 0;
        prev      = noteIndex;
        while (wraps < 3 && cyc < 400) begin
            step;
            cyc++;
            if (done) dones++;
            if (prev != 5'd0 && noteIndex == 5'd0) begin
                wraps++;
                check($sformatf("loop_pre_wrap_idx%0d", wraps), 32'(prev), 32'd4);
                if (wraps > 1) check($sformatf("loop_pass_len%0d", wraps), 32'(cyc - last_wrap), 32'd71);
                last_wrap = cyc;
            end
            prev = noteIndex;
        end
        check("loop_wraps", 32'(wraps), 32'd3);
        repeat (3) begin
            step;
            if (done) dones++;
        end
        check_outs("loop_playing", 4'h0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step;
        stop = 1'b0;
        if (done) dones++;
        check_outs("loop_stop_idle", 4'hF, 1'b0, 1'b0, 1'b0);
        check("loop_stop_idx", 32'(noteIndex), 32'd0);
        check("loop_no_done", 32'(dones), 32'd0);

        // Asynchronous reset in the middle of PLAY
        melodySel = 3'd1;
        start     = 1'b1;
        step;
        start     = 1'b0;
        repeat (4) step;
        check_outs("pre_reset_play", 4'h0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        check_outs("async_reset_outs", 4'hF, 1'b0, 1'b0, 1'b0);
        check("async_reset_idx", 32'(noteIndex), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        step;
        check_outs("after_reset_idle", 4'hF, 1'b0, 1'b0, 1'b0);
        melodySel = 3'd2;
        start     = 1'b1;
        step;
        start     = 1'b0;
        check_outs("after_reset_fetch", 4'hF, 1'b0, 1'b1, 1'b0);
        step;
        check_outs("after_reset_play", 4'h2, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step;
        stop = 1'b0;
        check_outs("final_stop", 4'hF, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
